// File: rtl/decode_issue_unit_seqtag.sv
// decode_issue_unit_seqtag
//   In-order, single-issue decode/issue stage. A circular fetch buffer feeds a
//   combinational decoder; a per-register pending bit + sequence tag
//   scoreboard blocks RAW hazards only. WAW is handled by tagging: only the
//   completion whose seq_num matches the latest issued writer updates the
//   regfile, so older completions are dropped as stale.
//
//   Optional feature (macro DECODE_ISSUE_COMPLETE_BYPASS_EN): a completion
//   that clears a source's pending bit this cycle also forwards C_wdata as
//   that operand, so the dependent issues in the completion cycle instead of
//   one cycle later.
//
//   uop encoding (X_uop): 0=ADD 1=ADDI 2=MUL 3=LW. Subsets are 4-bit masks
//   indexed by uop.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   F_val/F_rdy/F_*      fetch enqueue (inst, pc, seq_num)
//   X_val/X_rdy/X_*      per-pipe issue handshake + issued payload
//   C_*                  completion / regfile write notification
//   illegal              sticky flag: buffer head failed to decode
module decode_issue_unit_seqtag #(
  parameter logic [3:0] p_tinyrv1      = 4'b1111,
  parameter logic [3:0] p_isa_subset   = p_tinyrv1,
  parameter int         p_num_pipes    = 2,
  parameter logic [p_num_pipes-1:0][3:0] p_pipe_subsets = {p_num_pipes{p_tinyrv1}},
  parameter int         p_buf_depth    = 2,
  parameter int         p_seq_num_bits = 8
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      F_val,
  output logic                      F_rdy,
  input  logic [31:0]               F_inst,
  input  logic [31:0]               F_pc,
  input  logic [p_seq_num_bits-1:0] F_seq_num,
  output logic [p_num_pipes-1:0]    X_val,
  input  logic [p_num_pipes-1:0]    X_rdy,
  output logic [31:0]               X_pc,
  output logic [31:0]               X_op1,
  output logic [31:0]               X_op2,
  output logic [1:0]                X_uop,
  output logic [4:0]                X_waddr,
  output logic [p_seq_num_bits-1:0] X_seq_num,
  input  logic                      C_val,
  input  logic                      C_wen,
  input  logic [4:0]                C_waddr,
  input  logic [31:0]               C_wdata,
  input  logic [p_seq_num_bits-1:0] C_seq_num,
  output logic                      illegal
);
  localparam int PW  = (p_buf_depth > 1) ? $clog2(p_buf_depth) : 1;
  localparam int CW  = $clog2(p_buf_depth + 1);
  localparam int PPW = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;
  localparam int SW  = p_seq_num_bits;

  localparam logic [1:0] UOP_ADD = 2'd0, UOP_ADDI = 2'd1, UOP_MUL = 2'd2, UOP_LW = 2'd3;

  // fetch buffer
  logic [31:0]   r_inst [p_buf_depth];
  logic [31:0]   r_pc   [p_buf_depth];
  logic [SW-1:0] r_seq  [p_buf_depth];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          r_illegal;

  // scoreboard + regfile
  logic [31:0]   r_pend;
  logic [SW-1:0] r_tag [32];
  logic [31:0]   r_rf  [32];

  logic          w_empty, w_enq, w_fire, w_can, w_stall, w_legal;
  logic [31:0]   w_inst, w_imm, w_rs1_val, w_rs2_val;
  logic [4:0]    w_rs1, w_rs2, w_rd;
  logic [1:0]    w_uop;
  logic          w_dec_ok, w_use1, w_use2, w_wen, w_op2_sel;
  logic [PPW-1:0] w_pipe;
  logic          w_pipe_found, w_c_hit, w_byp1, w_byp2;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_buf_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_empty = (r_count == '0);
  assign F_rdy   = !rst && (r_count != CW'(p_buf_depth));
  assign w_enq   = F_val && F_rdy;
  assign illegal = r_illegal;

  // head decode
  assign w_inst = r_inst[r_head];
  assign w_rs1  = w_inst[19:15];
  assign w_rs2  = w_inst[24:20];
  assign w_rd   = w_inst[11:7];

  always_comb begin
    w_dec_ok  = 1'b0;
    w_uop     = UOP_ADD;
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_wen     = 1'b0;
    w_op2_sel = 1'b0;
    w_imm     = {{20{w_inst[31]}}, w_inst[31:20]};
    case (w_inst[6:0])
      7'b0110011: if (w_inst[14:12] == 3'b000) begin
        if (w_inst[31:25] == 7'b0000000) begin
          w_dec_ok = 1'b1; w_uop = UOP_ADD;
        end else if (w_inst[31:25] == 7'b0000001) begin
          w_dec_ok = 1'b1; w_uop = UOP_MUL;
        end
        w_use1 = 1'b1; w_use2 = 1'b1; w_wen = 1'b1;
      end
      7'b0010011: if (w_inst[14:12] == 3'b000) begin
        w_dec_ok = 1'b1; w_uop = UOP_ADDI;
        w_use1 = 1'b1; w_wen = 1'b1; w_op2_sel = 1'b1;
      end
      7'b0000011: if (w_inst[14:12] == 3'b010) begin
        w_dec_ok = 1'b1; w_uop = UOP_LW;
        w_use1 = 1'b1; w_wen = 1'b1; w_op2_sel = 1'b1;
      end
      default: ;
    endcase
  end

  // router: descending scan so the lowest-indexed capable pipe wins
  always_comb begin
    w_pipe       = '0;
    w_pipe_found = 1'b0;
    for (int i = p_num_pipes - 1; i >= 0; i--) begin
      if (p_pipe_subsets[i][w_uop]) begin
        w_pipe       = PPW'(i);
        w_pipe_found = 1'b1;
      end
    end
  end

  // a uop no pipe can execute would wedge the head, so treat it as illegal
  assign w_legal = w_dec_ok && p_isa_subset[w_uop] && w_pipe_found;

  assign w_c_hit = C_val && C_wen && (C_waddr != 5'd0) && r_pend[C_waddr] &&
                   (r_tag[C_waddr] == C_seq_num);

`ifdef DECODE_ISSUE_COMPLETE_BYPASS_EN
  assign w_byp1 = w_c_hit && (C_waddr == w_rs1);
  assign w_byp2 = w_c_hit && (C_waddr == w_rs2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : (w_byp1 ? C_wdata : r_rf[w_rs1]);
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : (w_byp2 ? C_wdata : r_rf[w_rs2]);

  // r_pend[0] is never set, so x0 sources never stall
  assign w_stall = (w_use1 && r_pend[w_rs1] && !w_byp1) ||
                   (w_use2 && r_pend[w_rs2] && !w_byp2);

  assign w_can  = !w_empty && w_legal && !r_illegal && !w_stall;
  assign w_fire = w_can && X_rdy[w_pipe];

  always_comb begin
    X_val         = '0;
    X_val[w_pipe] = w_can;
  end

  assign X_pc      = r_pc[r_head];
  assign X_op1     = w_rs1_val;
  assign X_op2     = w_op2_sel ? w_imm : w_rs2_val;
  assign X_uop     = w_uop;
  assign X_waddr   = w_rd;
  assign X_seq_num = r_seq[r_head];

  // buffer payload storage needs no reset; occupancy is tracked by r_count
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_inst[r_tail] <= F_inst;
      r_pc[r_tail]   <= F_pc;
      r_seq[r_tail]  <= F_seq_num;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_illegal <= 1'b0;
      r_pend    <= '0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      if (w_enq)  r_tail <= ptr_inc(r_tail);
      if (w_fire) r_head <= ptr_inc(r_head);
      case ({w_enq, w_fire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
      if (!w_empty && !w_legal) r_illegal <= 1'b1;
      if (w_c_hit) begin
        r_rf[C_waddr]   <= C_wdata;
        r_pend[C_waddr] <= 1'b0;
      end
      // issue set comes last so it overrides a same-register completion clear
      if (w_fire && w_wen && (w_rd != 5'd0)) r_pend[w_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_fire && w_wen && (w_rd != 5'd0)) r_tag[w_rd] <= X_seq_num;
  end
endmodule

// File: tb/tb_decode_issue_unit_seqtag.sv
module tb_decode_issue_unit_seqtag;
  localparam int NP = 2, DEPTH = 2, SB = 8;
  // pipe 0 lacks MUL (uop 2), pipe 1 supports everything
  localparam logic [NP-1:0][3:0] SUBS = {4'b1111, 4'b1011};
`ifdef DECODE_ISSUE_COMPLETE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic F_val = 0, F_rdy;
  logic [31:0] F_inst = 0, F_pc = 0;
  logic [SB-1:0] F_seq_num = 0;
  logic [NP-1:0] X_val, X_rdy = 0;
  logic [31:0] X_pc, X_op1, X_op2;
  logic [1:0] X_uop;
  logic [4:0] X_waddr;
  logic [SB-1:0] X_seq_num;
  logic C_val = 0, C_wen = 0;
  logic [4:0] C_waddr = 0;
  logic [31:0] C_wdata = 0;
  logic [SB-1:0] C_seq_num = 0;
  logic illegal;

  decode_issue_unit_seqtag #(.p_num_pipes(NP), .p_pipe_subsets(SUBS),
                             .p_buf_depth(DEPTH), .p_seq_num_bits(SB)) dut (
    .clk(clk), .rst(rst),
    .F_val(F_val), .F_rdy(F_rdy), .F_inst(F_inst), .F_pc(F_pc), .F_seq_num(F_seq_num),
    .X_val(X_val), .X_rdy(X_rdy), .X_pc(X_pc), .X_op1(X_op1), .X_op2(X_op2),
    .X_uop(X_uop), .X_waddr(X_waddr), .X_seq_num(X_seq_num),
    .C_val(C_val), .C_wen(C_wen), .C_waddr(C_waddr), .C_wdata(C_wdata),
    .C_seq_num(C_seq_num), .illegal(illegal));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd, rs1, rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  // ---------------- reference model ----------------
  typedef struct { bit ok; logic [1:0] uop; bit u1, u2, sel; logic [4:0] rs1, rs2, rd; logic [31:0] imm; } dec_t;
  typedef struct { logic [31:0] inst, pc; logic [SB-1:0] seq; } fe_t;
  typedef struct { logic [4:0] rd; logic [SB-1:0] seq; } fl_t;

  function automatic dec_t dec(input logic [31:0] in);
    dec_t d;
    d.ok = 0; d.uop = 0; d.u1 = 0; d.u2 = 0; d.sel = 0;
    d.rs1 = in[19:15]; d.rs2 = in[24:20]; d.rd = in[11:7];
    d.imm = {{20{in[31]}}, in[31:20]};
    if (in[6:0] == 7'h33 && in[14:12] == 3'd0 && in[31:25] == 7'd0) begin
      d.ok = 1; d.uop = 0; d.u1 = 1; d.u2 = 1;
    end else if (in[6:0] == 7'h33 && in[14:12] == 3'd0 && in[31:25] == 7'd1) begin
      d.ok = 1; d.uop = 2; d.u1 = 1; d.u2 = 1;
    end else if (in[6:0] == 7'h13 && in[14:12] == 3'd0) begin
      d.ok = 1; d.uop = 1; d.u1 = 1; d.sel = 1;
    end else if (in[6:0] == 7'h03 && in[14:12] == 3'd2) begin
      d.ok = 1; d.uop = 3; d.u1 = 1; d.sel = 1;
    end
    if (d.ok && !SUBS[0][d.uop] && !SUBS[1][d.uop]) d.ok = 0;
    return d;
  endfunction

  fe_t mq[$];
  fl_t infl[$];
  bit [31:0] m_pend;
  logic [SB-1:0] m_tag [32];
  logic [31:0] m_rf [32];
  bit m_ill = 0, m_live = 0;

  dec_t h;
  fe_t hd;
  logic [31:0] v1, v2;
  logic [NP-1:0] xv;
  bit chit, b1, b2, stall, can, fire, efrdy;
  int pipe;

  // Compare at negedge, then advance the model to what the next posedge
  // produces (inputs only change just after posedge, so they are stable here).
  always @(negedge clk) begin
    chit = C_val && C_wen && C_waddr != 0 && m_pend[C_waddr] && m_tag[C_waddr] == C_seq_num;
    efrdy = !rst && mq.size() < DEPTH;
    can = 0; pipe = 0; xv = '0; v1 = 0; v2 = 0;
    if (mq.size() > 0) begin
      hd = mq[0];
      h = dec(hd.inst);
      b1 = BYP && chit && C_waddr == h.rs1;
      b2 = BYP && chit && C_waddr == h.rs2;
      v1 = (h.rs1 == 0) ? 32'd0 : b1 ? C_wdata : m_rf[h.rs1];
      v2 = (h.rs2 == 0) ? 32'd0 : b2 ? C_wdata : m_rf[h.rs2];
      stall = (h.u1 && m_pend[h.rs1] && !b1) || (h.u2 && m_pend[h.rs2] && !b2);
      pipe = SUBS[0][h.uop] ? 0 : 1;
      can = h.ok && !m_ill && !stall;
      if (can) xv[pipe] = 1'b1;
    end
    fire = can && X_rdy[pipe];
    if (m_live) begin
      chk("F_rdy", F_rdy, efrdy);
      chk("X_val", X_val, xv);
      chk("illegal", illegal, m_ill);
      if (mq.size() > 0) begin
        chk("X_pc", X_pc, hd.pc);
        chk("X_seq_num", X_seq_num, hd.seq);
        chk("X_waddr", X_waddr, h.rd);
        if (h.ok) chk("X_uop", X_uop, h.uop);
        if (can) begin
          chk("X_op1", X_op1, v1);
          chk("X_op2", X_op2, h.sel ? h.imm : v2);
        end
      end
    end
    if (rst) begin
      mq.delete(); infl.delete();
      m_pend = 0; m_ill = 0; m_live = 1;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else if (m_live) begin
      if (mq.size() > 0 && !h.ok) m_ill = 1;
      if (chit) begin m_rf[C_waddr] = C_wdata; m_pend[C_waddr] = 0; end
      if (fire) begin
        void'(mq.pop_front());
        if (h.rd != 0) begin m_pend[h.rd] = 1; m_tag[h.rd] = hd.seq; end
        infl.push_back('{rd: h.rd, seq: hd.seq});
      end
      if (F_val && efrdy) mq.push_back('{inst: F_inst, pc: F_pc, seq: F_seq_num});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step; @(posedge clk); #1; endtask
  task automatic mid;  @(negedge clk); endtask
  task automatic fetch(input logic [31:0] inst, input logic [31:0] pc, input logic [SB-1:0] s);
    F_val = 1; F_inst = inst; F_pc = pc; F_seq_num = s;
  endtask
  task automatic comp(input logic [4:0] r, input logic [31:0] d, input logic [SB-1:0] s);
    C_val = 1; C_wen = 1; C_waddr = r; C_wdata = d; C_seq_num = s;
  endtask

  bit acc;
  logic [SB-1:0] rseq;
  logic [4:0] rd, ra, rb;
  int k;

  initial begin
    // reset
    rst = 1; step; step;
    mid; chk("rst F_rdy", F_rdy, 0); chk("rst X_val", X_val, 0); chk("rst illegal", illegal, 0);
    step; rst = 0;
    mid; chk("post-rst F_rdy", F_rdy, 1);

    // addi x1,x0,5 issues the cycle after enqueue
    fetch(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5), 32'h100, 8'd0); X_rdy = 2'b11;
    step; F_val = 0;
    mid; chk("addi X_val", X_val, 2'b01); chk("addi op2", X_op2, 5);
    chk("addi waddr", X_waddr, 1); chk("addi op1", X_op1, 0);
    step;

    // add x2,x1,x1 waits for x1
    fetch(enc_r(7'd0, 5'd2, 5'd1, 5'd1), 32'h104, 8'd1);
    step; F_val = 0;
    for (int i = 0; i < 3; i++) begin mid; chk("raw stall X_val", X_val, 0); step; end
    comp(5'd1, 32'd5, 8'd0);
    mid;
    if (BYP) begin
      chk("bypass X_val", X_val, 2'b01); chk("bypass op1", X_op1, 5); chk("bypass op2", X_op2, 5);
    end else chk("no-bypass stall X_val", X_val, 0);
    step; C_val = 0;
    if (!BYP) begin
      mid; chk("raw issue X_val", X_val, 2'b01); chk("raw op1", X_op1, 5); chk("raw op2", X_op2, 5);
      step;
    end
    comp(5'd2, 32'd10, 8'd1); step; C_val = 0;

    // WAW: back-to-back writers of x1, completions out of order
    fetch(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd1), 32'h200, 8'd4);
    step; fetch(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd2), 32'h204, 8'd5);
    mid; chk("waw1 X_val", X_val, 2'b01); chk("waw1 seq", X_seq_num, 4);
    step; F_val = 0;
    mid; chk("waw2 X_val", X_val, 2'b01); chk("waw2 seq", X_seq_num, 5);
    step;
    comp(5'd1, 32'd2, 8'd5); step;
    comp(5'd1, 32'd1, 8'd4); step; C_val = 0;
    fetch(enc_r(7'd0, 5'd3, 5'd1, 5'd0), 32'h208, 8'd6);
    step; F_val = 0;
    mid; chk("waw x1 read X_val", X_val, 2'b01); chk("waw x1 value", X_op1, 2);
    step; comp(5'd3, 32'd2, 8'd6); step; C_val = 0;

    // buffer full with no ready pipe, then in-order drain
    X_rdy = 2'b00;
    fetch(enc_i(7'h13, 3'd0, 5'd4, 5'd0, 12'd10), 32'h300, 8'd10);
    mid; chk("fill0 F_rdy", F_rdy, 1);
    step; fetch(enc_i(7'h13, 3'd0, 5'd4, 5'd0, 12'd11), 32'h304, 8'd11);
    mid; chk("fill1 F_rdy", F_rdy, 1);
    step; fetch(enc_i(7'h13, 3'd0, 5'd4, 5'd0, 12'd12), 32'h308, 8'd12);
    mid; chk("full F_rdy", F_rdy, 0); chk("full X_val", X_val, 2'b01);
    step;
    mid; chk("still full F_rdy", F_rdy, 0);
    step; X_rdy = 2'b01;
    mid; chk("drain seq a", X_seq_num, 10);
    step;
    mid; chk("drain seq b", X_seq_num, 11); chk("drain F_rdy", F_rdy, 1);
    step; F_val = 0;
    mid; chk("drain seq c", X_seq_num, 12);
    step;
    mid; chk("drained X_val", X_val, 0);
    comp(5'd4, 32'd12, 8'd12); step; C_val = 0;

    // MUL only on pipe 1
    fetch(enc_r(7'd1, 5'd5, 5'd0, 5'd0), 32'h400, 8'd20);
    step; F_val = 0;
    mid; chk("mul X_val", X_val, 2'b10);
    step;
    mid; chk("mul wait X_val", X_val, 2'b10);
    step; X_rdy = 2'b11;
    mid; chk("mul ready X_val", X_val, 2'b10); chk("mul uop", X_uop, 2);
    step;
    mid; chk("mul gone X_val", X_val, 0);
    comp(5'd5, 32'd0, 8'd20); step; C_val = 0;

    // illegal instruction blocks the buffer until reset
    fetch(32'hFFFF_FFFF, 32'h500, 8'd30);
    step; fetch(enc_i(7'h13, 3'd0, 5'd6, 5'd0, 12'd1), 32'h504, 8'd31);
    mid; chk("ill X_val", X_val, 0);
    step;
    mid; chk("ill sticky", illegal, 1); chk("ill X_val2", X_val, 0); chk("ill full F_rdy", F_rdy, 0);
    step; rst = 1; F_val = 0;
    step; rst = 0;
    mid; chk("ill rst illegal", illegal, 0); chk("ill rst F_rdy", F_rdy, 1); chk("ill rst X_val", X_val, 0);
    step;

    // randomized traffic, checked by the model each cycle
    rseq = 8'd40;
    for (int c = 0; c < 3000; c++) begin
      mid; acc = F_val && F_rdy;
      step;
      if (acc) rseq = rseq + 1'b1;
      if (acc || !F_val) begin
        rd = 5'($urandom_range(0, 7)); ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0: F_inst = enc_r(7'd0, rd, ra, rb);
          1: F_inst = enc_r(7'd1, rd, ra, rb);
          2: F_inst = enc_i(7'h13, 3'd0, rd, ra, 12'($urandom));
          default: F_inst = enc_i(7'h03, 3'd2, rd, ra, 12'($urandom));
        endcase
        F_pc = $urandom; F_seq_num = rseq;
        F_val = ($urandom_range(0, 3) != 0);
      end
      X_rdy = NP'($urandom);
      C_val = 0;
      if (infl.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, infl.size() - 1);
        comp(infl[k].rd, $urandom, infl[k].seq);
        infl.delete(k);
      end else if ($urandom_range(0, 7) == 0) begin
        comp(5'($urandom_range(0, 7)), $urandom, SB'($urandom));
      end
    end
    F_val = 0; C_val = 0;
    step; step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
